// File: rtl/truth_table_pkg.sv
// Shared FSM encoding and sizing helpers for the truth-table extractor.
// No datapath or timing of its own.
package truth_table_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam int SETTLE_W = 8;

  function automatic int rows(input int n);
    return 1 << n;
  endfunction

  // Row counter must be able to hold ROWS itself, hence the +1.
  function automatic int row_cnt_w(input int n);
    return $clog2(rows(n) + 1);
  endfunction

endpackage

// File: rtl/truth_table_extractor_settle_timer.sv
// Down-counter that holds each input vector for SETTLE_CYCLES clocks.
// o_expire is high in the last hold cycle; there is no backpressure.
module settle_timer
  import truth_table_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_count,
  output logic o_expire
);

  localparam logic [SETTLE_W-1:0] LOAD_VAL =
    (SETTLE_CYCLES > 0) ? SETTLE_W'(SETTLE_CYCLES - 1) : '0;

  logic [SETTLE_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (i_count && (r_cnt != '0)) begin
      r_cnt <= r_cnt - SETTLE_W'(1);
    end
  end

  assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/truth_table_extractor.sv
// Sweeps all input rows into a combinational DUT and builds its hex truth table; TRUTH_TABLE_EXTRACTOR_CHECK_EN adds a compare.
// done pulses ROWS*(SETTLE_CYCLES+1)+1 clks after start accept; start is ignored (not queued) unless the FSM is idle.
module truth_table_extractor
  import truth_table_pkg::*;
#(
  parameter int N_IN          = 3,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [N_IN-1:0]       dut_in,
  input  logic                  dut_out,
  output logic [(1<<N_IN)-1:0]  tt
`ifdef TRUTH_TABLE_EXTRACTOR_CHECK_EN
  ,
  input  logic [(1<<N_IN)-1:0]  expected,
  output logic                  mismatch,
  output logic [(1<<N_IN)-1:0]  mismatch_mask
`endif
);

  localparam int ROWS  = rows(N_IN);
  localparam int ROW_W = row_cnt_w(N_IN);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  state_t               r_state;
  logic [ROW_W-1:0]     r_row;
  logic [N_IN-1:0]      r_dut_in;
  logic [ROWS-1:0]      r_shadow;
  logic [ROWS-1:0]      r_tt;
  logic                 r_busy;
  logic                 r_done;
`ifdef TRUTH_TABLE_EXTRACTOR_CHECK_EN
  logic [ROWS-1:0]      r_expected;
  logic                 r_mismatch;
  logic [ROWS-1:0]      r_mismatch_mask;
`endif

  logic                 w_accept;
  logic                 w_last_row;
  logic                 w_load;
  logic                 w_expire;
  logic [ROW_W-1:0]     w_row_nxt;
  logic [N_IN-1:0]      w_idx;

  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_last_row = (r_row == LAST_ROW);
  assign w_row_nxt  = r_row + ROW_W'(1);
  // Row 0 is the MSB of the table: ROWS-1-row is the bitwise inverse of row.
  assign w_idx      = ~r_row[N_IN-1:0];
  assign w_load     = w_accept || ((r_state == S_SAMPLE) && !w_last_row);

  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_count (r_state == S_SETTLE),
    .o_expire(w_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_row    <= '0;
      r_dut_in <= '0;
      r_shadow <= '0;
      r_tt     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef TRUTH_TABLE_EXTRACTOR_CHECK_EN
      r_expected      <= '0;
      r_mismatch      <= 1'b0;
      r_mismatch_mask <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_row    <= '0;
            r_dut_in <= '0;
            r_busy   <= 1'b1;
            if (SETTLE_CYCLES == 0) r_state <= S_SAMPLE;
            else                    r_state <= S_SETTLE;
`ifdef TRUTH_TABLE_EXTRACTOR_CHECK_EN
            r_expected <= expected;
`endif
          end
        end
        S_SETTLE: begin
          if (w_expire) r_state <= S_SAMPLE;
        end
        S_SAMPLE: begin
          r_shadow[w_idx] <= dut_out;
          if (w_last_row) begin
            // busy drops as DONE is entered so it spans exactly the sweep.
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_dut_in <= '0;
          end else begin
            r_row    <= w_row_nxt;
            r_dut_in <= w_row_nxt[N_IN-1:0];
            if (SETTLE_CYCLES == 0) r_state <= S_SAMPLE;
            else                    r_state <= S_SETTLE;
          end
        end
        S_DONE: begin
          r_tt    <= r_shadow;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
`ifdef TRUTH_TABLE_EXTRACTOR_CHECK_EN
          r_mismatch_mask <= r_shadow ^ r_expected;
          r_mismatch      <= |(r_shadow ^ r_expected);
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign dut_in = r_dut_in;
  assign tt     = r_tt;
`ifdef TRUTH_TABLE_EXTRACTOR_CHECK_EN
  assign mismatch      = r_mismatch;
  assign mismatch_mask = r_mismatch_mask;
`endif

endmodule
